exu_issue_ctrl: RTL and testbench

//  Multi-cycle sequencer in front of the EXU. Accepts one decoded op from the IDU over valid/ready and registers its

---
 rtl/exu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_exu_issue_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_issue_ctrl.sv
// Issue sequencer between IDU and EXU: captures one op, runs it on the external EXU or an
// internal shift-add multiplier, then holds the result for WBU. Optional: EXU_CTRL_BYPASS_EN.
module exu_issue_ctrl #(
  parameter int              XLEN    = 32,
  parameter int              OPT_W   = 4,
  parameter int              SEL_W   = 3,
  parameter logic [OPT_W-1:0] OPT_MUL = 4'h2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [OPT_W-1:0] in_opt,
  input  logic [SEL_W-1:0] in_sel,
  output logic [XLEN-1:0]  exu_pc,
  output logic [XLEN-1:0]  exu_rs1,
  output logic [XLEN-1:0]  exu_rs2,
  output logic [XLEN-1:0]  exu_imm,
  output logic [OPT_W-1:0] exu_opt,
  output logic [SEL_W-1:0] exu_sel,
  input  logic [XLEN-1:0]  exu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic             busy
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1;
  logic [XLEN-1:0]  r_rs2;
  logic [XLEN-1:0]  r_imm;
  logic [OPT_W-1:0] r_opt;
  logic [SEL_W-1:0] r_sel;
  logic [XLEN-1:0]  r_out_data;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_fire;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [XLEN-1:0]  w_acc_step;

  always_comb begin
    w_in_ready = 1'b0;
`ifdef EXU_CTRL_BYPASS_EN
    // Draining the result and taking a new op in the same cycle keeps the pipe full.
    w_in_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
`else
    w_in_ready = !rst && (r_state == S_IDLE);
`endif
    w_accept   = in_valid && w_in_ready && !flush;
    w_out_fire = (r_state == S_DONE) && out_ready;
    w_is_mul   = (in_opt == OPT_MUL);
    w_mul_last = (r_cnt == CNT_W'(XLEN - 1));
    w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_is_mul ? S_MULT : S_EXEC;
      end
      S_EXEC: w_state_next = S_DONE;
      S_MULT: begin
        if (w_mul_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept)        w_state_next = w_is_mul ? S_MULT : S_EXEC;
        else if (w_out_fire) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_opt      <= '0;
      r_sel      <= '0;
      r_out_data <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_pc     <= in_pc;
        r_rs1    <= in_rs1;
        r_rs2    <= in_rs2;
        r_imm    <= in_imm;
        r_opt    <= in_opt;
        r_sel    <= in_sel;
        r_acc    <= '0;
        r_mcand  <= in_rs1;
        r_mplier <= in_rs2;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          S_EXEC: r_out_data <= exu_res;
          S_MULT: begin
            // Multiplicand walks left while multiplier bits are consumed LSB first.
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_mul_last) r_out_data <= w_acc_step;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign exu_pc    = r_pc;
  assign exu_rs1   = r_rs1;
  assign exu_rs2   = r_rs2;
  assign exu_imm   = r_imm;
  assign exu_opt   = r_opt;
  assign exu_sel   = r_sel;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl with a behavioural EXU and transaction-level model.
module tb_exu_issue_ctrl;

  localparam logic [3:0] EXU_ADD = 4'h0;
  localparam logic [3:0] OPT_MUL = 4'h2;
  localparam logic [2:0] SEL_RS1_ADD_RS2 = 3'h0;
  localparam int MUL_LAT = 33;
  localparam int ALU_LAT = 2;
`ifdef EXU_CTRL_BYPASS_EN
  localparam int B2B_GAP = 2;
`else
  localparam int B2B_GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [3:0]  in_opt = '0;
  logic [2:0]  in_sel = '0;
  logic [31:0] exu_pc, exu_rs1, exu_rs2, exu_imm, exu_res;
  logic [3:0]  exu_opt;
  logic [2:0]  exu_sel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural EXU: sel picks the operand pair, opt picks the operation.
  function automatic logic [31:0] exu_fn(input logic [3:0] opt, input logic [2:0] sel,
                                         input logic [31:0] pc, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [31:0] imm);
    logic [31:0] a, b;
    case (sel)
      3'd1:    begin a = rs1; b = imm; end
      3'd2:    begin a = pc;  b = imm; end
      default: begin a = rs1; b = rs2; end
    endcase
    case (opt)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd3:    return a ^ b;
      4'd4:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Expected WBU result of a transaction, straight from the op definition.
  function automatic logic [31:0] ref_result(input logic [3:0] opt, input logic [2:0] sel,
                                             input logic [31:0] pc, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [31:0] imm);
    if (opt == OPT_MUL) return rs1 * rs2;
    return exu_fn(opt, sel, pc, rs1, rs2, imm);
  endfunction

  assign exu_res = exu_fn(exu_opt, exu_sel, exu_pc, exu_rs1, exu_rs2, exu_imm);

  exu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_opt(in_opt), .in_sel(in_sel),
    .exu_pc(exu_pc), .exu_rs1(exu_rs1), .exu_rs2(exu_rs2), .exu_imm(exu_imm),
    .exu_opt(exu_opt), .exu_sel(exu_sel), .exu_res(exu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op, waits (bounded) for in_ready, returns one cycle after the accept edge.
  task automatic send_op(input logic [3:0] opt, input logic [2:0] sel, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         output bit ok);
    int w = 0;
    in_valid = 1'b1; in_opt = opt; in_sel = sel;
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    while (!in_ready && w < 100) begin tick(); w++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
    in_rs1 = $urandom; in_rs2 = $urandom;
  endtask

  // Latency counted in cycles from the accept cycle; stops at a bound.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b, required 0/0/0", in_ready, busy, out_valid);
    end
    n_checks++;
    if (out_data !== 32'h0 || exu_rs1 !== 32'h0 || exu_pc !== 32'h0 || exu_opt !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_regs: out_data=%h exu_rs1=%h exu_pc=%h exu_opt=%h, required all 0", out_data, exu_rs1, exu_pc, exu_opt);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_add();
    bit ok; int lat;
    send_op(EXU_ADD, SEL_RS1_ADD_RS2, 32'h100, 32'd5, 32'd7, 32'h0, ok);
    wait_valid(lat);
    n_checks++;
    if (lat !== ALU_LAT) begin
      n_fail++;
      $display("FAIL add_latency: got %0d, required %0d", lat, ALU_LAT);
    end
    n_checks++;
    if (out_data !== 32'd12) begin
      n_fail++;
      $display("FAIL add_data: got %h, required %h", out_data, 32'd12);
    end
    $display("add: 5+7 lat=%0d data=%h", lat, out_data);
    drain();
  endtask

  task automatic test_mul();
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] e [2];
    bit ok; int lat;
    a[0] = 32'h0000FFFF; b[0] = 32'h00010001; e[0] = 32'hFFFFFFFF;
    a[1] = 32'hFFFFFFFF; b[1] = 32'd2;        e[1] = 32'hFFFFFFFE;
    for (int i = 0; i < 2; i++) begin
      send_op(OPT_MUL, 3'd0, 32'h0, a[i], b[i], 32'h0, ok);
      wait_valid(lat);
      n_checks++;
      if (lat !== MUL_LAT) begin
        n_fail++;
        $display("FAIL mul_latency[%0d]: got %0d, required %0d", i, lat, MUL_LAT);
      end
      n_checks++;
      if (out_data !== e[i]) begin
        n_fail++;
        $display("FAIL mul_data[%0d]: got %h, required %h", i, out_data, e[i]);
      end
      $display("mul: %h*%h lat=%0d data=%h", a[i], b[i], lat, out_data);
      drain();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; bit bad = 0;
    send_op(4'd3, 3'd1, 32'h0, 32'hA5A5_0F0F, 32'h1, 32'hFFFF_0000, ok);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'h5A5A_0F0F || in_ready !== 1'b0) bad = 1;
      tick();
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure_hold: out_valid=%b data=%h in_ready=%b, required 1/5a5a0f0f/0", out_valid, out_data, in_ready);
    end
    drain();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: busy=%b out_valid=%b, required 0/0", busy, out_valid);
    end
    $display("backpressure: held 5 cycles data=%h", 32'h5A5A_0F0F);
  endtask

  task automatic test_flush();
    bit ok; bit seen = 0; logic [31:0] prev_rs1;
    send_op(OPT_MUL, 3'd0, 32'h0, 32'd1234, 32'd5678, 32'h0, ok);
    for (int i = 0; i < 9; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mul: busy=%b in_ready=%b out_valid=%b, required 0/1/0", busy, in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL flush_no_valid: out_valid observed 1, required never");
    end
    prev_rs1 = exu_rs1;
    flush = 1'b1; in_valid = 1'b1; in_opt = EXU_ADD; in_sel = 3'd0;
    in_rs1 = ~prev_rs1; in_rs2 = 32'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || exu_rs1 !== prev_rs1) begin
      n_fail++;
      $display("FAIL flush_accept: busy=%b exu_rs1=%h, required 0/%h", busy, exu_rs1, prev_rs1);
    end
    $display("flush: mul killed, idle flush+valid ignored");
  endtask

  task automatic test_reset_mid();
    bit ok; int lat;
    send_op(EXU_ADD, 3'd0, 32'h44, 32'd100, 32'd23, 32'h9, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || exu_rs1 !== 32'h0 ||
        exu_pc !== 32'h0 || exu_imm !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b ov=%b data=%h rs1=%h pc=%h imm=%h in_ready=%b, required 0/0/0/0/0/0/1",
               busy, out_valid, out_data, exu_rs1, exu_pc, exu_imm, in_ready);
    end
    send_op(EXU_ADD, SEL_RS1_ADD_RS2, 32'h0, 32'd5, 32'd7, 32'h0, ok);
    wait_valid(lat);
    n_checks++;
    if (lat !== ALU_LAT || out_data !== 32'd12) begin
      n_fail++;
      $display("FAIL reset_mid_next: lat=%0d data=%h, required %0d/%h", lat, out_data, ALU_LAT, 32'd12);
    end
    $display("reset_mid: recovered lat=%0d data=%h", lat, out_data);
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok; bit pend = 1; bit acc_now;
    int first = -1, second = -1;
    logic [31:0] d1 = '0, d2 = '0;
    out_ready = 1'b1;
    send_op(EXU_ADD, 3'd0, 32'h0, 32'd10, 32'd20, 32'h0, ok);
    in_valid = 1'b1; in_rs1 = 32'd300; in_rs2 = 32'd45;
    for (int k = 0; k < 16; k++) begin
      if (out_valid) begin
        if (first < 0) begin first = k; d1 = out_data; end
        else if (second < 0) begin second = k; d2 = out_data; end
      end
      acc_now = pend && in_valid && in_ready;
      tick();
      if (acc_now) begin in_valid = 1'b0; pend = 0; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (first < 0 || second < 0 || (second - first) != B2B_GAP) begin
      n_fail++;
      $display("FAIL b2b_gap: pulses at %0d and %0d, required gap %0d", first, second, B2B_GAP);
    end
    n_checks++;
    if (d1 !== 32'd30 || d2 !== 32'd345) begin
      n_fail++;
      $display("FAIL b2b_data: got %h,%h, required %h,%h", d1, d2, 32'd30, 32'd345);
    end
    $display("back_to_back: pulses at %0d,%0d data=%h,%h", first, second, d1, d2);
  endtask

  task automatic test_random();
    logic [3:0] opt; logic [2:0] sel;
    logic [31:0] pc, rs1, rs2, imm, exp_d;
    int lat, exp_lat, hold; bit ok, bad;
    for (int n = 0; n < 24; n++) begin
      opt = 4'($urandom_range(0, 5));
      sel = 3'($urandom_range(0, 3));
      pc = $urandom; rs1 = $urandom; rs2 = $urandom; imm = $urandom;
      if (n % 4 == 0) rs2 = 32'($urandom_range(0, 3));
      exp_d = ref_result(opt, sel, pc, rs1, rs2, imm);
      exp_lat = (opt == OPT_MUL) ? MUL_LAT : ALU_LAT;
      send_op(opt, sel, pc, rs1, rs2, imm, ok);
      wait_valid(lat);
      n_checks++;
      if (!ok || lat !== exp_lat || out_data !== exp_d) begin
        n_fail++;
        $display("FAIL rand_op[%0d]: ok=%b lat=%0d data=%h, required 1/%0d/%h", n, ok, lat, out_data, exp_lat, exp_d);
      end
      n_checks++;
      if (exu_rs1 !== rs1 || exu_rs2 !== rs2 || exu_pc !== pc || exu_imm !== imm ||
          exu_opt !== opt || exu_sel !== sel) begin
        n_fail++;
        $display("FAIL rand_operands[%0d]: rs1=%h rs2=%h pc=%h imm=%h, required %h %h %h %h",
                 n, exu_rs1, exu_rs2, exu_pc, exu_imm, rs1, rs2, pc, imm);
      end
      hold = $urandom_range(0, 3);
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (out_valid !== 1'b1 || out_data !== exp_d) bad = 1;
      end
      drain();
      n_checks++;
      if (bad || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_hold[%0d]: stable=%b busy=%b, required 1/0", n, !bad, busy);
      end
      $display("rand[%0d]: opt=%0d sel=%0d lat=%0d data=%h exp=%h", n, opt, sel, lat, out_data, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
